// File: rtl/ps2_receptor.sv
// rtl/ps2_receptor.sv - PS/2 keyboard frame receiver with clock glitch filter, parity/stop check and timeout
module ps2_receptor #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       err_tick
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        LOAD
    } state_t;

    logic                  ps2c_meta;
    logic                  ps2c_sync;
    logic                  ps2d_meta;
    logic                  ps2d_sync;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_ps2c_reg;
    logic                  f_ps2c_next;
    logic                  fall_edge;

    state_t                state_reg;
    state_t                state_next;
    logic [3:0]            n_reg;
    logic [3:0]            n_next;
    logic [9:0]            b_reg;
    logic [9:0]            b_next;
    logic [TW-1:0]         t_reg;
    logic [TW-1:0]         t_next;
    logic [7:0]            dout_next;
    logic                  done_next;
    logic                  err_next;

    // two-flop synchronisers for both asynchronous PS/2 lines; idle level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_meta <= 1'b1;
            ps2c_sync <= 1'b1;
            ps2d_meta <= 1'b1;
            ps2d_sync <= 1'b1;
        end else begin
            ps2c_meta <= ps2c;
            ps2c_sync <= ps2c_meta;
            ps2d_meta <= ps2d;
            ps2d_sync <= ps2d_meta;
        end
    end

    // filtered clock only changes once the whole sample window agrees
    always_comb begin
        f_ps2c_next = f_ps2c_reg;
        if (&filter_reg) begin
            f_ps2c_next = 1'b1;
        end else if (~|filter_reg) begin
            f_ps2c_next = 1'b0;
        end
    end

    // sample window shift, filtered level and registered falling-edge pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            filter_reg <= '1;
            f_ps2c_reg <= 1'b1;
            fall_edge  <= 1'b0;
        end else begin
            filter_reg <= {ps2c_sync, filter_reg[FILTER_LEN-1:1]};
            f_ps2c_reg <= f_ps2c_next;
            fall_edge  <= f_ps2c_reg & ~f_ps2c_next;
        end
    end

    // frame FSM state, shift register, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            n_reg        <= 4'd0;
            b_reg        <= 10'd0;
            t_reg        <= '0;
            dout         <= 8'h00;
            rx_done_tick <= 1'b0;
            err_tick     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            t_reg        <= t_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            err_tick     <= err_next;
        end
    end

    // next-state logic: start detect, bit shifting with timeout, frame validation
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        t_next     = t_reg;
        dout_next  = dout;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                t_next = '0;
                if (fall_edge && rx_en && !ps2d_sync) begin
                    n_next     = 4'd9;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    b_next = {ps2d_sync, b_reg[9:1]};
                    t_next = '0;
                    if (n_reg == 4'd0) begin
                        state_next = LOAD;
                    end else begin
                        n_next = n_reg - 4'd1;
                    end
                end else if (t_reg == TW'(TIMEOUT - 2)) begin
                    // counter is about to reach TIMEOUT-1: abandon the truncated frame
                    t_next     = '0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            LOAD: begin
                state_next = IDLE;
                // b_reg = {stop, parity, d7..d0}; odd parity means XOR over 9 bits is 1
                if (b_reg[9] && (^b_reg[8:0])) begin
                    dout_next = b_reg[7:0];
                    done_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_receptor.sv
// tb/tb_ps2_receptor.sv - self-checking bench for ps2_receptor
module tb_ps2_receptor;

    localparam int FL   = 8;
    localparam int TO   = 64;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2d;
    logic       ps2c;
    logic       rx_en;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       err_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = -1;
    int err_cyc  = -1;
    int last_fall_cyc = 0;
    logic [7:0] model_dout = 8'h00;

    always #5 clk = ~clk;

    ps2_receptor #(
        .FILTER_LEN(FL),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .rx_en       (rx_en),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .err_tick    (err_tick)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_tick === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (rx_done_tick === 1'b1 || err_tick === 1'b1) begin
            total++;
            assert (!(rx_done_tick === 1'b1 && err_tick === 1'b1)) else begin
                bad++;
                $error("FAIL tick_overlap: observed=both expected=one");
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop_val,
                              input int nbits, input bit glitch);
        logic [10:0] bits;
        bits = {stop_val, (~^data) ^ par_flip, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                wait_clks(14);
                ps2c = 1'b0;
                wait_clks(FL - 2);
                ps2c = 1'b1;
                wait_clks(10);
            end else begin
                wait_clks(HALF);
            end
            ps2c = 1'b0;
            last_fall_cyc = cyc;
            wait_clks(HALF);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] data, input logic par_flip,
                                input logic stop_val, input bit glitch);
        int   d0;
        int   e0;
        logic par;
        logic good;
        d0   = done_cnt;
        e0   = err_cnt;
        par  = (~^data) ^ par_flip;
        good = (stop_val == 1'b1) && ((^{par, data}) == 1'b1);
        send_frame(data, par_flip, stop_val, 11, glitch);
        if (good) model_dout = data;
        chk({tag, "_done"}, done_cnt - d0, good ? 1 : 0);
        chk({tag, "_err"}, err_cnt - e0, good ? 0 : 1);
        chk({tag, "_dout"}, {24'd0, dout}, {24'd0, model_dout});
        if (good) chk({tag, "_done_lat"}, done_cyc - last_fall_cyc, FL + 5);
        else      chk({tag, "_err_lat"}, err_cyc - last_fall_cyc, FL + 5);
    endtask

    initial begin
        int d0;
        int e0;
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        wait_clks(5);
        chk("reset_dout", {24'd0, dout}, 32'h0);
        chk("reset_done", {31'd0, rx_done_tick}, 32'h0);
        chk("reset_err", {31'd0, err_tick}, 32'h0);
        reset = 1'b0;
        wait_clks(30);

        expect_frame("f16", 8'h16, 1'b0, 1'b1, 1'b0);
        expect_frame("f1e", 8'h1E, 1'b0, 1'b1, 1'b0);
        expect_frame("f5a", 8'h5A, 1'b0, 1'b1, 1'b0);
        wait_clks(10);
        expect_frame("par_err", 8'h16, 1'b1, 1'b1, 1'b0);
        wait_clks(10);
        expect_frame("stop_err", 8'h16, 1'b0, 1'b0, 1'b0);
        wait_clks(10);
        expect_frame("glitch4d", 8'h4D, 1'b0, 1'b1, 1'b1);
        wait_clks(10);

        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        wait_clks(TO + FL + 20);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_done", done_cnt - d0, 0);
        chk("timeout_lat", err_cyc - last_fall_cyc, FL + 3 + TO);
        expect_frame("f21", 8'h21, 1'b0, 1'b1, 1'b0);
        wait_clks(10);

        rx_en = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
        wait_clks(TO + 20);
        chk("rxdis_done", done_cnt - d0, 0);
        chk("rxdis_err", err_cnt - e0, 0);
        chk("rxdis_dout", {24'd0, dout}, {24'd0, model_dout});
        rx_en = 1'b1;
        wait_clks(10);

        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h31, 1'b0, 1'b1, 5, 1'b0);
        reset = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        model_dout = 8'h00;
        wait_clks(TO + 30);
        chk("rst_mid_done", done_cnt - d0, 0);
        chk("rst_mid_err", err_cnt - e0, 0);
        chk("rst_mid_dout", {24'd0, dout}, 32'h0);
        expect_frame("f15", 8'h15, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 16; k++) begin
            logic [7:0] rd;
            logic       pf;
            logic       sv;
            bit         gl;
            rd = 8'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 3) != 0);
            gl = ($urandom_range(0, 1) == 1);
            wait_clks($urandom_range(0, 40));
            expect_frame("rand", rd, pf, sv, gl);
        end

        wait_clks(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
